// File: rtl/tdm_mux4_tx.sv
// Transmit end of a 1-to-4 select-routed link: captures a channel word and
// serialises it one slot at a time as a data bit plus its 2-bit select code.
module tdm_mux4_tx #(
  parameter int CHANNELS    = 4,
  parameter int HOLD_CYCLES = 1,
  parameter int HOLD_W      = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [CHANNELS-1:0] i_data,
  output logic                o_vout,
  output logic                o_a,
  output logic                o_b,
  output logic                o_en,
  output logic                o_sync,
  output logic                o_busy,
  output logic                o_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [1:0]        SLOT_LAST = 2'(CHANNELS - 1);

  state_t              state_q, state_d;
  logic [1:0]          slot_q, slot_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CHANNELS-1:0] data_q, data_d;

  logic [3:0] data_pad_s;
  logic       send_s;
  logic       vout_d, a_d, b_d, en_d, sync_d, busy_d, done_d;
  logic       vout_q, a_q, b_q, en_q, sync_q, busy_q, done_q;

  // Frame sequencing: capture, slot/hold stepping and the DONE turnaround.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    hold_d  = hold_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        slot_d = 2'd0;
        hold_d = '0;
        if (i_start) begin
          data_d  = i_data;
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (slot_q == SLOT_LAST) begin
            state_d = ST_DONE;
          end else begin
            slot_d = slot_q + 2'd1;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        slot_d  = 2'd0;
        hold_d  = '0;
      end
    endcase
  end

  // Outputs are precomputed from next state so they leave on flops aligned with it.
  always_comb begin
    data_pad_s                 = 4'd0;
    data_pad_s[CHANNELS-1:0]   = data_d;
    send_s = (state_d == ST_SEND);
    vout_d = send_s & data_pad_s[slot_d];
    a_d    = send_s & slot_d[1];
    b_d    = send_s & slot_d[0];
    en_d   = send_s;
    busy_d = send_s;
    sync_d = send_s && (slot_d == 2'd0) && (hold_d == '0);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      slot_q  <= 2'd0;
      hold_q  <= '0;
      data_q  <= '0;
      vout_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      en_q    <= 1'b0;
      sync_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      vout_q  <= vout_d;
      a_q     <= a_d;
      b_q     <= b_d;
      en_q    <= en_d;
      sync_q  <= sync_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_vout = vout_q;
  assign o_a    = a_q;
  assign o_b    = b_q;
  assign o_en   = en_q;
  assign o_sync = sync_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_tdm_mux4_tx.sv
// Bench for tdm_mux4_tx: table vectors, directed corner sequences and random
// traffic on a HOLD=1 and a HOLD=2 instance, both checked against a queue model.
module tb_tdm_mux4_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, start1, rst2, start2;
  logic [3:0] data1, data2;
  logic       v1, a1, b1, en1, sy1, bu1, dn1;
  logic       v2, a2, b2, en2, sy2, bu2, dn2;
  logic [6:0] out1, out2;

  assign out1 = {v1, a1, b1, en1, sy1, bu1, dn1};
  assign out2 = {v2, a2, b2, en2, sy2, bu2, dn2};

  tdm_mux4_tx #(.CHANNELS(4), .HOLD_CYCLES(1), .HOLD_W(4)) u_dut1 (
    .i_clk(clk), .i_rst(rst1), .i_start(start1), .i_data(data1),
    .o_vout(v1), .o_a(a1), .o_b(b1), .o_en(en1), .o_sync(sy1),
    .o_busy(bu1), .o_done(dn1)
  );

  tdm_mux4_tx #(.CHANNELS(4), .HOLD_CYCLES(2), .HOLD_W(4)) u_dut2 (
    .i_clk(clk), .i_rst(rst2), .i_start(start2), .i_data(data2),
    .o_vout(v2), .o_a(a2), .o_b(b2), .o_en(en2), .o_sync(sy2),
    .o_busy(bu2), .o_done(dn2)
  );

  int checks = 0;
  int errors = 0;

  // Model: queue of the per-cycle output words still to be shown, {vout,a,b,en,sync,busy,done}
  logic [6:0] mq0[$];
  logic [6:0] mq1[$];

  task automatic model_edge(input int u, input logic rst, input logic start,
                            input logic [3:0] data, input int hold);
    logic [6:0] q[$];
    logic       accept;
    logic [1:0] sel;
    if (u == 0) q = mq0; else q = mq1;
    if (rst) begin
      q.delete();
    end else begin
      accept = (q.size() == 0) || (q.size() == 1 && q[0][0]);
      if (q.size() > 0) void'(q.pop_front());
      if (accept && start) begin
        for (int n = 0; n < 4; n++) begin
          sel = 2'(n);
          for (int h = 0; h < hold; h++)
            q.push_back({data[n], sel[1], sel[0], 1'b1, (n == 0 && h == 0), 1'b1, 1'b0});
        end
        q.push_back(7'b0000001);
      end
    end
    if (u == 0) mq0 = q; else mq1 = q;
  endtask

  function automatic logic [6:0] model_out(input int u);
    if (u == 0) return (mq0.size() > 0) ? mq0[0] : 7'd0;
    return (mq1.size() > 0) ? mq1[0] : 7'd0;
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: drive both instances, step the model at the edge, compare on the falling edge.
  task automatic step(input logic r1, input logic s1, input logic [3:0] d1,
                      input logic r2, input logic s2, input logic [3:0] d2);
    rst1 = r1; start1 = s1; data1 = d1;
    rst2 = r2; start2 = s2; data2 = d2;
    @(posedge clk);
    model_edge(0, r1, s1, d1, 1);
    model_edge(1, r2, s2, d2, 2);
    @(negedge clk);
    check("model_h1", out1, model_out(0));
    check("model_h2", out2, model_out(1));
  endtask

  typedef struct packed {
    logic       rst;
    logic       start;
    logic [3:0] data;
    logic [6:0] exp;
  } vec_t;

  vec_t       tbl[8];
  logic [7:0] vseq;

  initial begin
    rst1 = 1'b1; start1 = 1'b0; data1 = 4'd0;
    rst2 = 1'b1; start2 = 1'b0; data2 = 4'd0;

    // Reset with start held, then the 4'b1010 frame on the HOLD=1 instance
    tbl[0] = '{1'b1, 1'b1, 4'b1010, 7'b0000000};
    tbl[1] = '{1'b1, 1'b1, 4'b1010, 7'b0000000};
    tbl[2] = '{1'b0, 1'b1, 4'b1010, 7'b0001110};
    tbl[3] = '{1'b0, 1'b0, 4'b0000, 7'b1011010};
    tbl[4] = '{1'b0, 1'b0, 4'b0000, 7'b0101010};
    tbl[5] = '{1'b0, 1'b0, 4'b0000, 7'b1111010};
    tbl[6] = '{1'b0, 1'b0, 4'b0000, 7'b0000001};
    tbl[7] = '{1'b0, 1'b0, 4'b0000, 7'b0000000};
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rst, tbl[i].start, tbl[i].data, tbl[i].rst, 1'b0, 4'd0);
      check($sformatf("table_%0d", i), out1, tbl[i].exp);
      if (i < 2) check("reset_h2", out2, 7'd0);
    end

    // HOLD=2 frame 4'b0110: serial bits 0,0,1,1,1,1,0,0 then done
    vseq = 8'b00111100;
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'b0110);
    check("h2_vout_0", {6'd0, v2}, {6'd0, vseq[7]});
    check("h2_sync_0", {6'd0, sy2}, 7'd1);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
      check($sformatf("h2_vout_%0d", i), {6'd0, v2}, {6'd0, vseq[7-i]});
      check($sformatf("h2_sync_%0d", i), {6'd0, sy2}, 7'd0);
    end
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    check("h2_done", {6'd0, dn2}, 7'd1);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    check("h2_idle", out2, 7'd0);

    // Start held with new data mid-frame must not restart or alter the frame
    step(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 4'd0);
    check("nostart_v0", {6'd0, v1}, 7'd1);
    vseq = 8'b00000000;
    for (int i = 1; i < 4; i++) begin
      step(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 4'd0);
      check($sformatf("nostart_v%0d", i), {6'd0, v1}, 7'd0);
      check($sformatf("nostart_sync%0d", i), {6'd0, sy1}, 7'd0);
    end
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    check("nostart_done", out1, 7'b0000001);

    // Start in the DONE cycle: straight back into slot 0 with sync
    step(1'b0, 1'b1, 4'b0101, 1'b0, 1'b0, 4'd0);
    check("b2b_slot0", out1, 7'b1001110);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    check("b2b_done", out1, 7'b0000001);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);

    // Reset during slot 2 aborts the frame with no done pulse
    step(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    check("abort_slot2", out1, 7'b1101010);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    check("abort_rst", out1, 7'd0);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    check("abort_nodone", out1, 7'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0), 4'($urandom),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
